// File: rtl/yutorina_sfr_console_if.sv
// -----------------------------------------------------------------------------
// yutorina_sfr_console_if
//   SFR port bundle between the CPU (master) and the console sink (slave).
//   The write side carries the active-low write strobe, address and data.
//   The read side carries the read address and the status word returned by
//   the console.
//
//   Signals
//     we_      master->slave  SFR write enable, active-low
//     wr_addr  master->slave  SFR write address
//     wr_data  master->slave  SFR write data
//     rd_addr  master->slave  SFR read address
//     rd_data  slave->master  read data (combinational in the slave)
// -----------------------------------------------------------------------------
interface yutorina_sfr_console_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              we_;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output we_, wr_addr, wr_data, rd_addr,
    input  rd_data
  );

  modport slave (
    input  we_, wr_addr, wr_data, rd_addr,
    output rd_data
  );
endinterface

// File: rtl/yutorina_sfr_console.sv
// -----------------------------------------------------------------------------
// yutorina_sfr_console
//   Console sink on the SFR write port. CPU writes to CONSOLE_ADDR enqueue
//   wr_data[7:0] into a small circular FIFO; a UART transmitter drains the
//   FIFO and shifts each byte out on txd, LSB first, one bit per CLK_DIV
//   clocks. A status word at STATUS_ADDR reports busy, full, a sticky
//   overflow flag and the FIFO level; writing 1 to bit 2 of STATUS_ADDR
//   clears overflow.
//
//   Ports
//     clk   in   clock
//     rst   in   reset, synchronous, active-high
//     sfr   slave modport of yutorina_sfr_console_if
//             we_/wr_addr/wr_data  write port (snooped)
//             rd_addr/rd_data      status read, rd_data combinational
//     txd   out  UART serial output, idle high, registered
//
//   Status word at STATUS_ADDR
//     [0]              busy      (transmitter active or FIFO not empty)
//     [1]              full
//     [2]              overflow  (sticky; a byte was dropped while full)
//     [FIFO_AW+8:8]    level     (0 .. 2**FIFO_AW)
//     all other bits 0; any other rd_addr reads 0.
//
//   Configuration
//     YUTORINA_SFR_CONSOLE_PARITY_EN  defined   -> 8E1 frame (even parity
//                                                  bit after data, 11 bits)
//                                     undefined -> 8N1 frame (10 bits)
// -----------------------------------------------------------------------------
module yutorina_sfr_console #(
  parameter int                ADDR_W       = 5,
  parameter int                DATA_W       = 32,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 5'd2,
  parameter logic [ADDR_W-1:0] STATUS_ADDR  = 5'd3,
  parameter int                CLK_DIV      = 434,
  parameter int                FIFO_AW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  yutorina_sfr_console_if.slave sfr,
  output logic                  txd
);

  localparam int DEPTH  = 1 << FIFO_AW;
  localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [FIFO_AW:0]  FULL_LVL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [BAUD_W-1:0]  baud_q,   baud_d;
  logic [2:0]         bit_q,    bit_d;
  logic [7:0]         shift_q,  shift_d;
  logic               txd_q,    txd_d;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
  logic               par_q,    par_d;
`endif

  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q,  level_d;
  logic               ovf_q,    ovf_d;
  logic [7:0]         mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Decode and FIFO status
  // ---------------------------------------------------------------------------
  logic       push_req;
  logic       push;
  logic       pop;
  logic       empty;
  logic       full;
  logic       ovf_set;
  logic       ovf_clr;
  logic       bit_end;
  logic       busy;
  logic [7:0] head;

  // Only the low byte of wr_data is consumed (plus bit 2 for the status
  // clear); the upper bits are folded here so they read as intentionally
  // unused.
  logic unused_wr_hi;
  assign unused_wr_hi = ^sfr.wr_data[DATA_W-1:8];

  assign push_req = !sfr.we_ && (sfr.wr_addr == CONSOLE_ADDR);
  assign ovf_clr  = !sfr.we_ && (sfr.wr_addr == STATUS_ADDR) && sfr.wr_data[2];
  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LVL);
  assign head     = mem_q[rd_ptr_q];
  assign bit_end  = (baud_q == BAUD_LAST);
  assign busy     = (state_q != S_IDLE) || !empty;

  // A pop on the same edge frees a slot, so a write into a full FIFO is still
  // accepted then and the level stays put.
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  // ---------------------------------------------------------------------------
  // Transmitter FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so the block is
    // purely combinational and no latch is inferred.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
    par_d   = par_q;
`endif

    // Baud counter free-runs 0..CLK_DIV-1 while a frame is on the line.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          txd_d   = 1'b0;
          baud_d  = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
          par_d   = shift_q[0];
`endif
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
            // par_q now holds the XOR of all eight data bits sent.
            txd_d   = par_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
            par_d   = par_q ^ shift_q[0];
`endif
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more bytes wait.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            txd_d   = 1'b0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, level and overflow flag
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A new overflow outranks a clear landing on the same edge.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // NOTE: the FIFO storage has no reset; clearing the pointers and level
  // makes any stale contents unreachable, and a plain RAM maps cleanly.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sfr.wr_data[7:0];
    end
  end

  assign txd = txd_q;

  // ---------------------------------------------------------------------------
  // Status read
  // ---------------------------------------------------------------------------
  always_comb begin
    sfr.rd_data = '0;
    if (sfr.rd_addr == STATUS_ADDR) begin
      sfr.rd_data[0]           = busy;
      sfr.rd_data[1]           = full;
      sfr.rd_data[2]           = ovf_q;
      sfr.rd_data[FIFO_AW+8:8] = level_q;
    end
  end

endmodule

// File: tb/tb_yutorina_sfr_console.sv
// -----------------------------------------------------------------------------
// tb_yutorina_sfr_console
//   Directed bench for yutorina_sfr_console with CLK_DIV=4, FIFO_AW=2.
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_yutorina_sfr_console;

  localparam int CLK_DIV = 4;
  localparam int FIFO_AW = 2;
  localparam logic [4:0] CON_A = 5'd2;
  localparam logic [4:0] STA_A = 5'd3;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd;

  int n_tests = 0;
  int n_fail  = 0;

  yutorina_sfr_console_if #(.ADDR_W(5), .DATA_W(32)) sfr_if ();

  yutorina_sfr_console #(
    .ADDR_W      (5),
    .DATA_W      (32),
    .CONSOLE_ADDR(CON_A),
    .STATUS_ADDR (STA_A),
    .CLK_DIV     (CLK_DIV),
    .FIFO_AW     (FIFO_AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sfr(sfr_if),
    .txd(txd)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one SFR write so it is captured at the next rising edge.
  task automatic sfr_write(input logic [4:0] addr, input logic [31:0] data);
    sfr_if.we_     = 1'b0;
    sfr_if.wr_addr = addr;
    sfr_if.wr_data = data;
    tick();
    sfr_if.we_     = 1'b1;
    sfr_if.wr_data = 32'hDEAD_BE00;
  endtask

  // Check txd once per cycle over a full frame starting at the current cycle.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [10:0] v;
`ifdef YUTORINA_SFR_CONSOLE_PARITY_EN
    v = {1'b1, ^b, b, 1'b0};
`else
    v = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int i = 0; i < NBITS; i++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        check($sformatf("%s_bit%0d_c%0d", tag, i, c), {31'b0, txd}, {31'b0, v[i]});
        tick();
      end
    end
  endtask

  initial begin
    int lows;
    rst             = 1'b1;
    sfr_if.we_      = 1'b1;
    sfr_if.wr_addr  = '0;
    sfr_if.wr_data  = '0;
    sfr_if.rd_addr  = STA_A;

    // Reset state.
    tick();
    tick();
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_status", sfr_if.rd_data, 32'h0000_0000);
    rst = 1'b0;
    tick();
    check("idle_status", sfr_if.rd_data, 32'h0000_0000);

    // Single frame 0x141: upper bits ignored, byte 0x41 sent.
    sfr_write(CON_A, 32'h0000_0141);
    check("wr_queued_status", sfr_if.rd_data, 32'h0000_0101);
    check("wr_txd_still_idle", {31'b0, txd}, 32'd1);
    tick();
    check("start_status", sfr_if.rd_data, 32'h0000_0001);
    expect_frame(8'h41, "f41");
    check("f41_done_status", sfr_if.rd_data, 32'h0000_0000);
    check("f41_done_txd", {31'b0, txd}, 32'd1);

    // Parity-distinguishing pattern 0x43 (three ones).
    sfr_write(CON_A, 32'h0000_0043);
    tick();
    expect_frame(8'h43, "f43");
    check("f43_done_status", sfr_if.rd_data, 32'h0000_0000);

    // Back-to-back 'A','B': no idle gap between frames.
    sfr_write(CON_A, 32'h0000_0041);
    sfr_write(CON_A, 32'h0000_0042);
    check("ab_status", sfr_if.rd_data, 32'h0000_0101);
    expect_frame(8'h41, "fA");
    expect_frame(8'h42, "fB");
    check("ab_done_status", sfr_if.rd_data, 32'h0000_0000);

    // Six consecutive writes: first popped, four queued, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      sfr_write(CON_A, 32'h0000_0010 + 32'(i));
    end
    check("ovf_status", sfr_if.rd_data, 32'h0000_0407);
    sfr_if.rd_addr = CON_A;
    #1;
    check("other_rd_addr", sfr_if.rd_data, 32'h0000_0000);
    sfr_if.rd_addr = STA_A;
    #1;
    sfr_write(STA_A, 32'hFFFF_FFFB);
    check("ovf_not_cleared", sfr_if.rd_data, 32'h0000_0407);
    sfr_write(STA_A, 32'h0000_0004);
    check("ovf_cleared", sfr_if.rd_data, 32'h0000_0403);

    // Frame of 0x10 started one edge after the first write; move into data
    // bit 3 (a zero) and reset there.
    for (int i = 0; i < 11; i++) tick();
    check("pre_rst_bit3", {31'b0, txd}, 32'd0);
    rst = 1'b1;
    tick();
    check("midrst_txd", {31'b0, txd}, 32'd1);
    check("midrst_status", sfr_if.rd_data, 32'h0000_0000);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 20 * CLK_DIV; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    check("post_rst_no_frames", 32'(lows), 32'd0);
    check("post_rst_status", sfr_if.rd_data, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
